// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the nn_mult front-end datapath.
package nn_pkg;

    localparam int unsigned NN_LANES = 8;
    localparam int unsigned NN_DW    = 17;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } feeder_state_e;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_vec_feeder_if.sv
// Pair stream in, nn_mult operand/result bus, and result stream out.
interface nn_vec_feeder_if
    import nn_pkg::*;
#(
    parameter int unsigned LANES = NN_LANES,
    parameter int unsigned DW    = NN_DW
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DW-1:0]         s_x;
    logic [DW-1:0]         s_w;
    logic                  s_last;

    logic                  mult_ce;
    logic [LANES*DW-1:0]   mult_x;
    logic [LANES*DW-1:0]   mult_w;
    logic [DW-1:0]         mult_total;

    logic                  r_valid;
    logic                  r_ready;
    logic [DW-1:0]         r_data;

    modport slave (
        input  s_valid, s_x, s_w, s_last, mult_total, r_ready,
        output s_ready, mult_ce, mult_x, mult_w, r_valid, r_data
    );

    modport master (
        output s_valid, s_x, s_w, s_last, mult_total, r_ready,
        input  s_ready, mult_ce, mult_x, mult_w, r_valid, r_data
    );

endinterface

// File: rtl/nn_lane_packer.sv
// Lane register bank: writes pairs at a running index, zero-clears, and
// presents the lanes as packed x/w buses (lane k at bits [k*DW +: DW]).
module nn_lane_packer
    import nn_pkg::*;
#(
    parameter int unsigned LANES = NN_LANES,
    parameter int unsigned DW    = NN_DW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en_i,
    input  logic                              clr_i,
    input  logic [DW-1:0]                     x_i,
    input  logic [DW-1:0]                     w_i,
    output logic [clog2_min1(LANES)-1:0]      idx_o,
    output logic [LANES*DW-1:0]               x_o,
    output logic [LANES*DW-1:0]               w_o
);

    localparam int unsigned IDX_W = clog2_min1(LANES);

    logic [LANES-1:0][DW-1:0] x_q;
    logic [LANES-1:0][DW-1:0] w_q;
    logic [IDX_W-1:0]         idx_q;

    // Untouched lanes keep their cleared value, giving zero padding for short vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            w_q   <= '0;
            idx_q <= '0;
        end else if (clr_i) begin
            x_q   <= '0;
            w_q   <= '0;
            idx_q <= '0;
        end else if (wr_en_i) begin
            x_q[idx_q] <= x_i;
            w_q[idx_q] <= w_i;
            if (idx_q != IDX_W'(LANES - 1)) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign idx_o = idx_q;
    assign x_o   = x_q;
    assign w_o   = w_q;

endmodule

// File: rtl/nn_vec_feeder.sv
// Front-end driver for nn_mult: packs (x, w) pairs into lanes, runs the
// multiplier for its pipeline latency, and returns the captured total.
module nn_vec_feeder
    import nn_pkg::*;
#(
    parameter int unsigned LANES    = NN_LANES,
    parameter int unsigned DW       = NN_DW,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    nn_vec_feeder_if.slave  bus
);

    localparam int unsigned IDX_W = clog2_min1(LANES);
    localparam int unsigned LAT_W = clog2_min1(MULT_LAT);

    feeder_state_e     state_q;
    logic [LAT_W-1:0]  lat_q;
    logic              s_ready_q;
    logic              mult_ce_q;
    logic              r_valid_q;
    logic [DW-1:0]     r_data_q;

    logic [IDX_W-1:0]  idx;
    logic              wr_en_c;
    logic              clr_c;
    logic              fill_done_c;

    assign wr_en_c     = (state_q == FILL) && s_ready_q && bus.s_valid;
    assign clr_c       = (state_q == HOLD) && bus.r_ready;
    assign fill_done_c = wr_en_c && (bus.s_last || (idx == IDX_W'(LANES - 1)));

    nn_lane_packer #(
        .LANES (LANES),
        .DW    (DW)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_en_c),
        .clr_i   (clr_c),
        .x_i     (bus.s_x),
        .w_i     (bus.s_w),
        .idx_o   (idx),
        .x_o     (bus.mult_x),
        .w_o     (bus.mult_w)
    );

    // Control FSM; every handshake/enable output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            lat_q     <= '0;
            s_ready_q <= 1'b1;
            mult_ce_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_done_c) begin
                        state_q   <= RUN;
                        s_ready_q <= 1'b0;
                        mult_ce_q <= 1'b1;
                        lat_q     <= '0;
                    end
                end
                RUN: begin
                    if (lat_q == LAT_W'(MULT_LAT - 1)) begin
                        state_q   <= CAPT;
                        mult_ce_q <= 1'b0;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                CAPT: begin
                    r_data_q  <= bus.mult_total;
                    r_valid_q <= 1'b1;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (bus.r_ready) begin
                        r_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.mult_ce = mult_ce_q;
    assign bus.r_valid = r_valid_q;
    assign bus.r_data  = r_data_q;

endmodule

// File: tb/tb_nn_vec_feeder.sv
// Directed and randomized bench for nn_vec_feeder with a ce-gated nn_mult stub.
module tb_nn_vec_feeder;
    import nn_pkg::*;

    localparam int unsigned LANES = NN_LANES;
    localparam int unsigned DW    = NN_DW;
    localparam int unsigned W     = LANES * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nn_vec_feeder_if #(.LANES(LANES), .DW(DW)) bus ();

    nn_vec_feeder #(
        .LANES    (LANES),
        .DW       (DW),
        .MULT_LAT (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // nn_mult stand-in: low DW bits of the dot product through two ce-gated stages.
    logic [DW-1:0] st1 = '0;
    logic [DW-1:0] st2 = '0;

    function automatic logic [DW-1:0] stub_dot(input logic [W-1:0] xs, input logic [W-1:0] ws);
        logic [63:0] acc;
        acc = 64'd0;
        for (int k = 0; k < int'(LANES); k++) begin
            acc = acc + 64'(xs[k*DW +: DW]) * 64'(ws[k*DW +: DW]);
        end
        return acc[DW-1:0];
    endfunction

    always @(posedge clk) begin
        if (bus.mult_ce) begin
            st1 <= stub_dot(bus.mult_x, bus.mult_w);
            st2 <= st1;
        end
    end
    assign bus.mult_total = st2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int unsigned vx [LANES];
    int unsigned vw [LANES];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the vector is the first n pairs; the rest of the lanes are zero.
    function automatic logic [DW-1:0] model_sum(input int n);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < n; i++) s += longint'(vx[i]) * longint'(vw[i]);
        return DW'(s);
    endfunction

    function automatic logic [W-1:0] model_lanes(input bit use_w, input int n);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*DW +: DW] = DW'(use_w ? vw[i] : vx[i]);
        return v;
    endfunction

    task automatic run_vec(input string tag, input int n, input bit gaps,
                           input int hold_cycles, input int exp_lit);
        logic [W-1:0]  ex;
        logic [W-1:0]  ew;
        logic [DW-1:0] er;
        int sent;
        int budget;
        int ce_cnt;
        int lat;
        bit toggle;
        ex = model_lanes(1'b0, n);
        ew = model_lanes(1'b1, n);
        er = (exp_lit >= 0) ? DW'(exp_lit) : model_sum(n);
        sent = 0; budget = 0; ce_cnt = 0; lat = 0; toggle = 1'b0;
        bus.r_ready = (hold_cycles == 0);

        while (sent < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (gaps && toggle) begin
                bus.s_valid = 1'b0;
                bus.s_x     = DW'($urandom);
                bus.s_w     = DW'($urandom);
                bus.s_last  = 1'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_x     = DW'(vx[sent]);
                bus.s_w     = DW'(vw[sent]);
                bus.s_last  = (sent == n - 1);
                if (bus.s_ready) sent++;
            end
            toggle = ~toggle;
        end
        check({tag, " pairs_sent"}, W'(sent), W'(n));

        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                check({tag, " mult_x"}, bus.mult_x, ex);
                check({tag, " mult_w"}, bus.mult_w, ew);
                check({tag, " s_ready_run"}, W'(bus.s_ready), W'(0));
            end
            if (bus.mult_ce) ce_cnt++;
            if (bus.r_valid) begin
                lat = j;
                break;
            end
        end
        check({tag, " r_valid_latency"}, W'(lat), W'(4));
        check({tag, " ce_cycles"}, W'(ce_cnt), W'(2));
        check({tag, " r_data"}, W'(bus.r_data), W'(er));
        check({tag, " mult_x_held"}, bus.mult_x, ex);

        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_x     = DW'($urandom);
            bus.s_w     = DW'($urandom);
            check({tag, " hold_r_valid"}, W'(bus.r_valid), W'(1));
            check({tag, " hold_r_data"}, W'(bus.r_data), W'(er));
            check({tag, " hold_s_ready"}, W'(bus.s_ready), W'(0));
        end
        bus.s_valid = 1'b0;
        bus.r_ready = 1'b1;

        @(negedge clk);
        check({tag, " r_valid_drop"}, W'(bus.r_valid), W'(0));
        check({tag, " s_ready_back"}, W'(bus.s_ready), W'(1));
        check({tag, " lanes_cleared"}, bus.mult_x, W'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
        bus.s_w     = '0;
        bus.s_last  = 1'b0;
        bus.r_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst s_ready", W'(bus.s_ready), W'(1));
        check("rst mult_ce", W'(bus.mult_ce), W'(0));
        check("rst mult_x", bus.mult_x, W'(0));
        check("rst mult_w", bus.mult_w, W'(0));
        check("rst r_valid", W'(bus.r_valid), W'(0));
        check("rst r_data", W'(bus.r_data), W'(0));
        rst_n = 1'b1;

        for (int i = 0; i < int'(LANES); i++) begin vx[i] = i + 1; vw[i] = 1; end
        run_vec("full", 8, 1'b0, 0, 36);

        vx[0] = 2; vw[0] = 3;
        vx[1] = 4; vw[1] = 5;
        vx[2] = 6; vw[2] = 7;
        run_vec("short", 3, 1'b0, 0, 68);

        for (int i = 0; i < int'(LANES); i++) begin vx[i] = i + 1; vw[i] = 2; end
        run_vec("backpressure", 8, 1'b0, 10, 72);

        for (int i = 0; i < int'(LANES); i++) begin vx[i] = i + 1; vw[i] = 1; end
        run_vec("gaps", 8, 1'b1, 0, 36);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_x     = DW'(i + 10);
            bus.s_w     = DW'(i + 20);
            bus.s_last  = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst mult_x", bus.mult_x, W'(0));
        check("midrst s_ready", W'(bus.s_ready), W'(1));
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.r_valid) seen++;
        end
        check("midrst no_r_valid", W'(seen), W'(0));

        for (int i = 0; i < int'(LANES); i++) begin vx[i] = 2; vw[i] = 2; end
        run_vec("after_rst", 8, 1'b0, 0, 32);

        vx[0] = 100; vw[0] = 3;
        run_vec("single", 1, 1'b0, 0, 300);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, LANES));
            for (int i = 0; i < int'(LANES); i++) begin
                vx[i] = $urandom_range(0, (1 << DW) - 1);
                vw[i] = $urandom_range(0, (1 << DW) - 1);
            end
            run_vec($sformatf("rand%0d", r), n, r[0], (r == 3) ? 3 : 0, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nn_vec_feeder.md
# nn_vec_feeder

Front-end driver for the `nn_mult` dot-product unit. It accepts a stream of (sample, weight) pairs over a valid/ready handshake and packs them lane by lane into the packed `x`/`w` buses that `nn_mult` consumes. It gates `nn_mult`'s clock enable for the multiplier's pipeline latency, captures the 17-bit `total`, and returns it on a valid/ready result port. It sits between the feature-extraction stream and `nn_mult` in the neuro_skin datapath.

## Interface
Parameters:
- `LANES`, default 8: lanes per vector.
- `DW`, default 17: width of each sample, weight and result word.
- `MULT_LAT`, default 2: number of ce-enabled rising edges after which `mult_total` reflects the presented vector. Must be ≥1.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  input pair valid.
- `s_ready`  out  1  feeder can accept a pair.
- `s_x`  in  DW  sample.
- `s_w`  in  DW  weight.
- `s_last`  in  1  this pair closes the vector; remaining lanes are zero-padded.
- `mult_ce`  out  1  clock enable to `nn_mult`.
- `mult_x`  out  LANES*DW  packed samples; lane k occupies bits [k*DW+DW-1 : k*DW].
- `mult_w`  out  LANES*DW  packed weights, same lane mapping as `mult_x`.
- `mult_total`  in  DW  result from `nn_mult`.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  downstream accepts the result.
- `r_data`  out  DW  captured dot-product result.

## Operation
- FSM states: FILL, RUN, CAPT, HOLD. The reset state is FILL.
- **FILL**
  - `s_ready`=1.
  - On each handshake (`s_valid`&`s_ready`), `s_x`/`s_w` are written into lane `idx` and `idx` increments. The first accepted pair goes to lane 0.
  - Leave for RUN when the accepted pair fills lane LANES-1, or when `s_last`=1 on the accepted pair. Lanes above the last written one hold 0.
  - `s_last` on lane 0 is legal and produces a 1-lane vector.
  - `s_last` on lane LANES-1 is equivalent to a full vector.
- **RUN**
  - `s_ready`=0, `mult_ce`=1.
  - A latency counter counts MULT_LAT cycles, then the FSM moves to CAPT.
- **CAPT**
  - `mult_ce`=0.
  - `r_data`<=`mult_total` at the end of this cycle, `r_valid`<=1, and the FSM moves to HOLD.
- **HOLD**
  - `r_valid`=1 and `r_data` is stable.
  - On `r_ready`, `r_valid`<=0, lane registers and `idx` clear, and the FSM returns to FILL.
- `mult_x`/`mult_w` are held constant from RUN entry until HOLD exit.
- No arithmetic is done in the feeder. `r_data` is `mult_total` passed through bit-exact; overflow and rounding are `nn_mult`'s responsibility.
- Reset values: `s_ready`=1 (FILL), `mult_ce`=0, `mult_x`=0, `mult_w`=0, `r_valid`=0, `r_data`=0.
- Asserting `rst_n` low mid-vector or mid-RUN discards the partial vector and any pending result with no output pulse. The next vector starts at lane 0.

## Timing
- T is the cycle of the final-lane (or `s_last`) handshake. Then:
  - `mult_ce`=1 in cycles T+1 … T+MULT_LAT.
  - CAPT occurs at T+MULT_LAT+1.
  - `r_valid` rises at T+MULT_LAT+2.
- Minimum vector period is LANES + MULT_LAT + 2 cycles with `r_ready` tied high.
- `s_ready` is a function of state only; it does not depend on `s_valid` combinationally.
- `r_valid`, once asserted, never drops without `r_ready`.
- `s_valid` asserted while `s_ready`=0 is ignored; data must be held by the source.

## Structure
- Shared package `nn_pkg` holds:
  - constants `NN_LANES`=8, `NN_DW`=17;
  - the feeder state enum (FILL/RUN/CAPT/HOLD).
- Sub-module `nn_lane_packer` is the lane register bank with write index `idx`, zero-clear, and packed `x`/`w` outputs. The FSM and latency counter stay in `nn_vec_feeder`.

## Test plan
The bench drives `mult_total` from a stub computing the low DW bits of Σ x·w through MULT_LAT=2 ce-gated stages.

- Full vector: x=1..8 (lanes 0..7), w=1 each, `r_ready`=1 → `r_data`=36. `r_valid` rises exactly 4 cycles after the lane-7 handshake, and `mult_ce` is high for exactly 2 cycles.
- Short vector: 3 pairs (2,3),(4,5),(6,7) with `s_last` on the third → lanes 3..7 are 0 and `r_data`=68.
- Backpressure: `r_ready`=0 for 10 cycles after `r_valid` → `r_valid` and `r_data` stay stable, `s_ready` stays 0, and the next vector is accepted only after the handshake.
- Source gaps: `s_valid` toggled 1/0 every cycle over a full vector → identical result to the gap-free case, and no lane is skipped or duplicated.
- Reset mid-fill: after 5 pairs, pulse `rst_n` low for 1 cycle → no `r_valid` occurs, and a following full vector x=w=2 gives `r_data`=32.
- Single lane: one pair (x=100, w=3) with `s_last` → `r_data`=300, and `mult_x` bits above lane 0 are 0.
